// File: rtl/image_stage_sequencer.sv
// Run controller: starts grayscale, AMBTC compress and base-3 encode engines in order and
// routes the single image port to the active engine. Define SEQ_WATCHDOG_EN for the per-stage timeout.
module image_stage_sequencer #(
  parameter int ADDR_W  = 6,
  parameter int PIX_W   = 24,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 20000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [2:0]            eng_start,
  input  logic [2:0]            eng_done,
  input  logic [3*ADDR_W-1:0]   eng_row,
  input  logic [3*ADDR_W-1:0]   eng_col,
  input  logic [2:0]            eng_we,
  input  logic [3*PIX_W-1:0]    eng_pix,
  output logic [ADDR_W-1:0]     row,
  output logic [ADDR_W-1:0]     col,
  output logic                  out_we,
  output logic [PIX_W-1:0]      out_pix,
  output logic [1:0]            stage,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_W-1:0]      cycle_cnt
);

  // Stage states are encoded so that state[1:0] equals the reported stage number.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GRAY = 3'd1;
  localparam logic [2:0] S_COMP = 3'd2;
  localparam logic [2:0] S_ENC  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("image_stage_sequencer: TIMEOUT must be at least 2");
  end

  logic [2:0]        state_reg, state_next;
  logic [2:0]        eng_start_reg, eng_start_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
  logic [CNT_W-1:0]  cycle_cnt_reg, cycle_cnt_next;
  logic              in_stage;
  logic              done_sel;
  logic              done_hit;

  logic [ADDR_W-1:0] row_arr [3];
  logic [ADDR_W-1:0] col_arr [3];
  logic [PIX_W-1:0]  pix_arr [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_slice
    assign row_arr[gi] = eng_row[gi*ADDR_W +: ADDR_W];
    assign col_arr[gi] = eng_col[gi*ADDR_W +: ADDR_W];
    assign pix_arr[gi] = eng_pix[gi*PIX_W +: PIX_W];
  end

  assign in_stage = (state_reg == S_GRAY) || (state_reg == S_COMP) || (state_reg == S_ENC);
  assign cnt_inc  = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    done_sel = 1'b0;
    case (state_reg)
      S_GRAY:  done_sel = eng_done[0];
      S_COMP:  done_sel = eng_done[1];
      S_ENC:   done_sel = eng_done[2];
      default: done_sel = 1'b0;
    endcase
  end

  // The entry cycle is the one carrying the start pulse; a done seen then is stale.
  assign done_hit = in_stage && (eng_start_reg == 3'b000) && done_sel;

`ifdef SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  logic error_reg, error_next;
`endif

  always_comb begin
    state_next     = state_reg;
    cycle_cnt_next = cycle_cnt_reg;
`ifdef SEQ_WATCHDOG_EN
    error_next     = error_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_GRAY;
      end
      S_GRAY, S_COMP, S_ENC: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (done_hit) begin
          state_next     = (state_reg == S_ENC) ? S_FIN : state_reg + 3'd1;
          cycle_cnt_next = cnt_inc;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (cnt_reg == WD_LAST) begin
          state_next = S_ERR;
          error_next = 1'b1;
        end
`endif
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      S_ERR: begin
        if (start) begin
          state_next = S_GRAY;
`ifdef SEQ_WATCHDOG_EN
          error_next = 1'b0;
`endif
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    eng_start_next = 3'b000;
    if (state_next != state_reg) begin
      case (state_next)
        S_GRAY:  eng_start_next = 3'b001;
        S_COMP:  eng_start_next = 3'b010;
        S_ENC:   eng_start_next = 3'b100;
        default: eng_start_next = 3'b000;
      endcase
    end
  end

  // Counter reads 0 on the entry cycle, so the stored count is cnt+1 on the done cycle.
  always_comb begin
    if (state_next != state_reg) cnt_next = '0;
    else if (in_stage)           cnt_next = cnt_inc;
    else                         cnt_next = cnt_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      eng_start_reg <= 3'b000;
      cnt_reg       <= '0;
      cycle_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      eng_start_reg <= eng_start_next;
      cnt_reg       <= cnt_next;
      cycle_cnt_reg <= cycle_cnt_next;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) error_reg <= 1'b0;
    else        error_reg <= error_next;
  end
  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    row     = '0;
    col     = '0;
    out_we  = 1'b0;
    out_pix = '0;
    case (state_reg)
      S_GRAY: begin
        row = row_arr[0]; col = col_arr[0]; out_we = eng_we[0]; out_pix = pix_arr[0];
      end
      S_COMP: begin
        row = row_arr[1]; col = col_arr[1]; out_we = eng_we[1]; out_pix = pix_arr[1];
      end
      S_ENC: begin
        row = row_arr[2]; col = col_arr[2]; out_we = eng_we[2]; out_pix = pix_arr[2];
      end
      default: ;
    endcase
  end

  assign eng_start = eng_start_reg;
  assign busy      = in_stage;
  assign done      = (state_reg == S_FIN);
  assign stage     = in_stage ? state_reg[1:0] : 2'd0;
  assign cycle_cnt = cycle_cnt_reg;

endmodule

// File: tb/tb_image_stage_sequencer.sv
// Directed bench for image_stage_sequencer: cycle table plus hand-written run, reset and watchdog sequences.
module tb_image_stage_sequencer;

  localparam int ADDR_W = 6;
  localparam int PIX_W  = 24;
  localparam int CNT_W  = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start, abort;
  logic [2:0]          eng_start, eng_done, eng_we;
  logic [3*ADDR_W-1:0] eng_row, eng_col;
  logic [3*PIX_W-1:0]  eng_pix;
  logic [ADDR_W-1:0]   row, col;
  logic                out_we;
  logic [PIX_W-1:0]    out_pix;
  logic [1:0]          stage;
  logic                busy, done, error;
  logic [CNT_W-1:0]    cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  image_stage_sequencer #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .CNT_W(CNT_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .eng_start(eng_start), .eng_done(eng_done),
    .eng_row(eng_row), .eng_col(eng_col), .eng_we(eng_we), .eng_pix(eng_pix),
    .row(row), .col(col), .out_we(out_we), .out_pix(out_pix),
    .stage(stage), .busy(busy), .done(done), .error(error), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        ab;
    logic [2:0]  dn;
    logic [2:0]  es;
    logic [1:0]  sg;
    logic        b;
    logic        d;
    logic [15:0] cc;
  } vec_t;

  vec_t vecs [18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected image port for a given stage, from the fixed engine drive values.
  task automatic chk_port(input string tag, input logic [1:0] sg);
    logic [5:0] r, c;
    logic       w;
    logic [23:0] p;
    case (sg)
      2'd1:    begin r = 6'd1; c = 6'd2; w = 1'b1; p = 24'h110000; end
      2'd2:    begin r = 6'd5; c = 6'd9; w = 1'b1; p = 24'h00AB00; end
      2'd3:    begin r = 6'd3; c = 6'd4; w = 1'b0; p = 24'h0000CC; end
      default: begin r = 6'd0; c = 6'd0; w = 1'b0; p = 24'h000000; end
    endcase
    chk({tag, ".row"}, 32'(row), 32'(r));
    chk({tag, ".col"}, 32'(col), 32'(c));
    chk({tag, ".we"},  32'(out_we), 32'(w));
    chk({tag, ".pix"}, 32'(out_pix), 32'(p));
  endtask

  task automatic chk_all(input string tag, input logic [2:0] es, input logic [1:0] sg,
                         input logic b, input logic d, input logic err, input logic [15:0] cc);
    chk({tag, ".eng_start"}, 32'(eng_start), 32'(es));
    chk({tag, ".stage"},     32'(stage), 32'(sg));
    chk({tag, ".busy"},      32'(busy), 32'(b));
    chk({tag, ".done"},      32'(done), 32'(d));
    chk({tag, ".error"},     32'(error), 32'(err));
    chk({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(cc));
    chk_port(tag, sg);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; eng_done = 3'b000;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    // start, abort, done -> eng_start, stage, busy, done, cycle_cnt
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 3'b001, 2'd1, 1'b1, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 3'b111, 3'b000, 2'd1, 1'b1, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 3'b110, 3'b000, 2'd1, 1'b1, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, 3'b001, 3'b010, 2'd2, 1'b1, 1'b0, 16'd3};
    vecs[4]  = '{1'b0, 1'b0, 3'b010, 3'b000, 2'd2, 1'b1, 1'b0, 16'd3};
    vecs[5]  = '{1'b0, 1'b0, 3'b010, 3'b100, 2'd3, 1'b1, 1'b0, 16'd2};
    vecs[6]  = '{1'b0, 1'b0, 3'b100, 3'b000, 2'd3, 1'b1, 1'b0, 16'd2};
    vecs[7]  = '{1'b1, 1'b0, 3'b100, 3'b000, 2'd0, 1'b0, 1'b1, 16'd2};
    vecs[8]  = '{1'b1, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 16'd2};
    vecs[9]  = '{1'b1, 1'b0, 3'b000, 3'b001, 2'd1, 1'b1, 1'b0, 16'd2};
    vecs[10] = '{1'b0, 1'b0, 3'b000, 3'b000, 2'd1, 1'b1, 1'b0, 16'd2};
    vecs[11] = '{1'b0, 1'b0, 3'b001, 3'b010, 2'd2, 1'b1, 1'b0, 16'd2};
    vecs[12] = '{1'b0, 1'b0, 3'b000, 3'b000, 2'd2, 1'b1, 1'b0, 16'd2};
    vecs[13] = '{1'b0, 1'b1, 3'b010, 3'b000, 2'd0, 1'b0, 1'b0, 16'd2};
    vecs[14] = '{1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 16'd2};
    vecs[15] = '{1'b0, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 16'd2};
    vecs[16] = '{1'b1, 1'b0, 3'b000, 3'b001, 2'd1, 1'b1, 1'b0, 16'd2};
    vecs[17] = '{1'b0, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 16'd2};

    eng_row = {6'd3, 6'd5, 6'd1};
    eng_col = {6'd4, 6'd9, 6'd2};
    eng_we  = 3'b011;
    eng_pix = {24'h0000CC, 24'h00AB00, 24'h110000};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; eng_done = 3'b000;

    #2;
    chk_all("reset", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    do_reset();
    chk_all("idle", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < 18; i++) begin
      start = vecs[i].st; abort = vecs[i].ab; eng_done = vecs[i].dn;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].es, vecs[i].sg, vecs[i].b, vecs[i].d, 1'b0, vecs[i].cc);
    end
    start = 1'b0; abort = 1'b0; eng_done = 3'b000;
    step();
    $display("table: %0d vectors applied", 18);

    // Full run with each engine answering 10 cycles after its start pulse.
    start = 1'b1;
    for (int n = 1; n <= 35; n++) begin
      step();
      start = 1'b0;
      chk($sformatf("run.c%0d.eng_start", n), 32'(eng_start),
          32'((n == 1) ? 3'b001 : (n == 12) ? 3'b010 : (n == 23) ? 3'b100 : 3'b000));
      chk($sformatf("run.c%0d.done", n), 32'(done), 32'(n == 34));
      if (n == 34) chk("run.cycle_cnt", 32'(cycle_cnt), 32'd11);
      if (n == 35) chk("run.end_stage", 32'(stage), 32'd0);
      eng_done = (n == 11) ? 3'b001 : (n == 22) ? 3'b010 : (n == 33) ? 3'b100 : 3'b000;
    end
    eng_done = 3'b000;
    step();
    $display("run: 10-cycle engines completed");

    // Async reset on the cycle the done pulse would appear.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    eng_done = 3'b001;
    step();
    eng_done = 3'b000;
    step();
    eng_done = 3'b010;
    step();
    eng_done = 3'b000;
    step();
    chk_all("pre_rst", 3'b000, 2'd3, 1'b1, 1'b0, 1'b0, 16'd2);
    eng_done = 3'b100;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    step();
    chk_all("rst_edge", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1; eng_done = 3'b000;
    step();
    chk_all("post_rst", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    $display("reset: mid-run reset applied");

`ifdef SEQ_WATCHDOG_EN
    start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      start = 1'b0;
      if (n == 8) chk_all("wd.last_gray", 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 16'd0);
      if (n == 9) chk_all("wd.err", 3'b000, 2'd0, 1'b0, 1'b0, 1'b1, 16'd0);
      if (n == 12) chk("wd.err_held", 32'(error), 32'd1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("wd.restart", 3'b001, 2'd1, 1'b1, 1'b0, 1'b0, 16'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_all("wd.abort", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    $display("watchdog: timeout sequence applied");
`else
    start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      step();
      start = 1'b0;
    end
    chk_all("nowd.stuck", 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 16'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_all("nowd.abort", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    $display("no-watchdog: long stage without timeout applied");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_stage_sequencer.md
# image_stage_sequencer

- Top-level run controller for the steganography pipeline.
- Runs the three image engines in fixed order: grayscale, AMBTC compress, base-3 encode.
- Each engine gets a one-cycle start pulse; the sequencer waits for that engine's done.
- Owns the single image access port (row/col address, write enable, write pixel) and routes it to the active engine only.
- Reports busy/done/error status plus a per-stage cycle count.

## Interface
- ADDR_W, 6: row/col width (64x64 image)
- PIX_W, 24: pixel width (R 23:16, G 15:8, B 7:0)
- CNT_W, 16: stage cycle counter width
- TIMEOUT, 20000: max cycles per stage before error (watchdog builds only)
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a run (single-cycle pulse)
- abort  in  1  abandon the current run
- eng_start  out  3  one-hot start pulse; bit0 gray, bit1 compress, bit2 encode
- eng_done  in  3  per-engine done, same bit order
- eng_row, eng_col  in  3*ADDR_W  per-engine address; engine k at [k*ADDR_W +: ADDR_W]
- eng_we  in  3  per-engine write enable
- eng_pix  in  3*PIX_W  per-engine write pixel
- row, col  out  ADDR_W  image address
- out_we  out  1  image write enable
- out_pix  out  PIX_W  image write pixel
- stage  out  2  0 idle, 1 gray, 2 compress, 3 encode
- busy  out  1  high while in GRAY/COMP/ENC
- done  out  1  one-cycle pulse at run completion
- error  out  1  sticky watchdog error
- cycle_cnt  out  CNT_W  cycle count of the last completed stage

## Operation
- States: IDLE, GRAY, COMP, ENC, FIN, ERR.
- IDLE: start -> GRAY.
- GRAY: eng_done[0] -> COMP.
- COMP: eng_done[1] -> ENC.
- ENC: eng_done[2] -> FIN.
- FIN: unconditionally -> IDLE.
- ERR: start -> GRAY; also clears error.
- Abort in GRAY/COMP/ENC -> IDLE. No done pulse; error unchanged.
- Abort has priority over eng_done in the same cycle.
- Start while busy, or while in FIN, is ignored.
- eng_start[k] is registered and high exactly on the first cycle in stage k. It is never high in any other state.
- eng_done is qualified by the active stage. Done bits from inactive engines are ignored.
- eng_done is sampled starting on the cycle after the start pulse. A done that is already high on the entry cycle is ignored.
- Port mux is combinational and selected by the current state:
  - Active engine k drives row, col, out_we, out_pix.
  - In IDLE, FIN and ERR: row=0, col=0, out_we=0, out_pix=0.
- Stage counter:
  - Cleared on stage entry; increments every cycle in the stage; saturates at all-ones.
  - On stage exit by done, the counter value is copied to cycle_cnt. That value is the number of cycles from entry to the done cycle, inclusive.
  - On abort or error, cycle_cnt holds its previous value.
- Status decode: busy = state in {GRAY, COMP, ENC}; done = state FIN.

## Timing
- Reset values:
  - state IDLE
  - eng_start 0, stage 0, busy 0, done 0, error 0, cycle_cnt 0
  - row 0, col 0, out_we 0, out_pix 0
- Start sampled at cycle T: state GRAY and eng_start=3'b001 at T+1; busy=1 at T+1.
- Done sampled at cycle D during GRAY: COMP and eng_start=3'b010 at D+1. COMP -> ENC behaves the same way.
- eng_done[2] at cycle E: done=1, busy=0, stage=0 at E+1; IDLE at E+2.
- Back-to-back runs: a start at E+2 is accepted.
- Minimum run length: 7 cycles from start to done pulse (each engine returns done 1 cycle after its start).
- Async reset mid-run: outputs return to reset values immediately. Engines receive no further start pulses.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - If the stage counter reaches TIMEOUT-1 without a qualifying done, the next state is ERR and error=1 (sticky).
  - eng_done in that same cycle wins over the timeout.
  - Abort in that same cycle wins over both.
- SEQ_WATCHDOG_EN undefined:
  - No timeout logic; ERR is unreachable.
  - error is tied to 0 and the TIMEOUT parameter is unused.

## Test plan
- Reset, then start at T; each engine returns done 10 cycles after its start -> eng_start 001/010/100 at T+1/T+12/T+23; done pulse at T+34; cycle_cnt=11.
- Engine 1 drives row=5, col=9, we=1, pix=24'h00AB00 while stage=1 (gray) -> port shows engine 0 values; during COMP the port shows row=5, col=9, we=1, pix=24'h00AB00; in IDLE the port is all zero.
- During GRAY pulse eng_done[1] and eng_done[2] -> state stays GRAY; a later eng_done[0] advances to COMP.
- Abort and eng_done[1] in the same COMP cycle -> IDLE next cycle; no done pulse; no eng_start[2].
- With SEQ_WATCHDOG_EN and TIMEOUT=8, eng_done never asserted -> ERR 8 cycles after GRAY entry, error=1 held; a later start clears error and re-enters GRAY.
- rst_n low on the cycle the done pulse would assert -> done stays 0; all outputs read 0 asynchronously.
